rx_peak_identification_param: RTL
=================================

// Module: rx_peak_identification_param
// PURPOSE
//  Parametrised next-generation peak identifier for the RX chain, between the per-sequence correlator bank and the ARM interface.
//  - Arming: opens a search window when the band-pass sample exceeds a runtime threshold.
//  - Search: tracks per-channel correlation maxima with timestamps.
//  - Scan: walks the channels to find the best and second-best peak.
//  - Report: holds the result under a valid/acquired handshake, then applies a hold-off before re-arming.
// PARAMETERS
//  N_SEQ     16  number of correlation channels (>=2)
//  CORR_W    41  signed correlation width
//  SAMPLE_W  16  signed filtered-sample width
//  TIME_W    32  timestamp width (full width is reported, no truncation)
//  WIN_W     16  width of window/hold-off counters
//  SEQ_W     $clog2(N_SEQ)  channel index width (localparam)
// PORTS
//  crx_clk              in   1               clock
//  rrx_rst              in   1               synchronous active-high reset
//  erx_en               in   1               enable; low = synchronous clear, same as reset
//  ithreshold           in   SAMPLE_W        signed arming threshold
//  iwindow_len          in   WIN_W           search window length in samples (0 treated as 1)
//  ihold_off            in   WIN_W           samples ignored after acquisition
//  isample_filtered     in   SAMPLE_W        signed band-pass output
//  inew_sample_trigger  in   1               one-cycle strobe: new sample/correlations valid
//  icurrent_time        in   TIME_W          timestamp captured with each new maximum
//  icorrelation         in   N_SEQ*CORR_W    flat signed correlations; channel k = [k*CORR_W +: CORR_W]
//  iresult_acquired     in   1               consumer ack of the reported result
//  o_peak_value         out  CORR_W          best peak value (signed)
//  o_second_value       out  CORR_W          second-best channel peak (signed)
//  o_peak_seq           out  SEQ_W           index of the best channel
//  o_peak_time          out  TIME_W          timestamp of the best peak
//  o_valid              out  1               result valid; held until acknowledged
//  o_busy               out  1               high in every state except IDLE
// BEHAVIOUR
//  Reset / erx_en low: state IDLE; all outputs 0; counters 0; per-channel maxima = most-negative CORR_W value; timestamps 0.
//  FSM states: IDLE -> SEARCH -> SCAN -> REPORT -> HOLDOFF -> IDLE.
//  IDLE:
//   - Arms on inew_sample_trigger && (isample_filtered > ithreshold), using a signed compare.
//   - Loads the maxima with the arming sample's correlations and timestamps.
//   - Sets the sample counter to 1, then -> SEARCH.
//   - If the effective window length is 1, goes straight to SCAN instead.
//  SEARCH, on each inew_sample_trigger:
//   - Per channel k: if corr[k] > max[k] (strict, signed), load max[k] and time[k] <= icurrent_time; ties keep the earlier time.
//   - Increment the counter.
//   - When the updated count equals the effective window length, -> SCAN on the next cycle.
//   - Threshold crossings inside the window do not restart or extend it.
//  SCAN:
//   - Exactly N_SEQ cycles; index i = 0..N_SEQ-1, one channel per cycle.
//   - Running best and second-best registers both start at most-negative.
//   - If max[i] > best: second <= best, best <= max[i] with its seq and time.
//   - Else if max[i] > second: second <= max[i].
//   - Equal values keep the lower index as best.
//  REPORT:
//   - Entered the cycle after scan index N_SEQ-1; results are copied to the outputs and o_valid=1 in that same cycle.
//   - Latency: N_SEQ+1 clocks from the window-closing trigger to o_valid.
//   - Outputs and o_valid are held stable until iresult_acquired is sampled high; o_valid drops on the next edge, then -> HOLDOFF.
//   - iresult_acquired outside REPORT is ignored.
//   - Triggers during SCAN/REPORT are ignored (no arming, no accumulation).
//  HOLDOFF:
//   - Counts ihold_off triggers, then -> IDLE; ihold_off = 0 goes to IDLE the next cycle.
//   - Output values persist until the next REPORT overwrites them.
//  Entering SEARCH from IDLE always re-initialises the maxima; nothing carries over between windows.
//  Reset or erx_en low mid-operation:
//   - Returns to IDLE next edge and drops o_valid.
//   - No partial result is ever flagged valid.
//  Counter widths: WIN_W; the window counter never wraps, because it saturates at the effective length.
// TESTING
//  1 Arming: thr=800, window=4, filtered=800 then 801 -> arms only on 801; o_busy rises the next cycle.
//  2 Argmax/timing: N_SEQ=16, window=4, ch5 peaks 1000 at t=102, ch9 peaks 900, other channels <=100 ->
//    o_peak_seq=5, o_peak_value=1000, o_second_value=900, o_peak_time=102, o_valid exactly 17 clocks after the 4th trigger.
//  3 Ties and negatives: all channels constant -50 -> seq=0, value=-50, second=-50; equal peaks on ch3 and ch7 -> seq=3.
//  4 Handshake: hold iresult_acquired low 20 cycles -> o_valid and outputs stable;
//    pulse ack -> o_valid=0 next cycle; crossing sample during REPORT does not arm.
//  5 Hold-off: ihold_off=3, crossing on triggers 1-3 after ack ignored, crossing on trigger 4 arms;
//    ihold_off=0 -> arms on the first trigger.
//  6 Abort: erx_en low at SCAN index 7 -> o_valid never asserts, outputs 0, state IDLE;
//    re-enable plus crossing -> a full window is rerun.

Source files
------------

// File: rtl/rx_peak_identification_param.sv
// RX peak identifier: a threshold crossing opens a search window that tracks
// per-channel correlation maxima with timestamps. The channels are then scanned
// for the best and second-best peak, the result is held under a valid/acquired
// handshake, and a hold-off period of ignored samples follows before re-arming.
module rx_peak_identification_param #(
  parameter int N_SEQ    = 16,
  parameter int CORR_W   = 41,
  parameter int SAMPLE_W = 16,
  parameter int TIME_W   = 32,
  parameter int WIN_W    = 16
) (
  input  logic                      crx_clk,
  input  logic                      rrx_rst,
  input  logic                      erx_en,
  input  logic [SAMPLE_W-1:0]       ithreshold,
  input  logic [WIN_W-1:0]          iwindow_len,
  input  logic [WIN_W-1:0]          ihold_off,
  input  logic [SAMPLE_W-1:0]       isample_filtered,
  input  logic                      inew_sample_trigger,
  input  logic [TIME_W-1:0]         icurrent_time,
  input  logic [N_SEQ*CORR_W-1:0]   icorrelation,
  input  logic                      iresult_acquired,
  output logic [CORR_W-1:0]         o_peak_value,
  output logic [CORR_W-1:0]         o_second_value,
  output logic [$clog2(N_SEQ)-1:0]  o_peak_seq,
  output logic [TIME_W-1:0]         o_peak_time,
  output logic                      o_valid,
  output logic                      o_busy
);

  localparam int SEQ_W = $clog2(N_SEQ);
  localparam logic signed [CORR_W-1:0] MOST_NEG = {1'b1, {(CORR_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SCAN,
    ST_REPORT,
    ST_HOLDOFF
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                     w_clear;
  logic                     w_arm;
  logic [WIN_W-1:0]         w_win_eff;
  logic [WIN_W:0]           w_cnt_inc;

  logic signed [CORR_W-1:0] w_corr [N_SEQ];
  logic signed [CORR_W-1:0] w_scan_val;

  logic [WIN_W-1:0]         r_cnt;
  logic signed [CORR_W-1:0] r_max  [N_SEQ];
  logic [TIME_W-1:0]        r_time [N_SEQ];

  logic [SEQ_W-1:0]         r_idx;
  logic signed [CORR_W-1:0] r_best;
  logic signed [CORR_W-1:0] r_second;
  logic [SEQ_W-1:0]         r_best_seq;
  logic [TIME_W-1:0]        r_best_time;

  logic [CORR_W-1:0]        r_out_value;
  logic [CORR_W-1:0]        r_out_second;
  logic [SEQ_W-1:0]         r_out_seq;
  logic [TIME_W-1:0]        r_out_time;
  logic                     r_valid;

  assign w_clear    = rrx_rst || !erx_en;
  assign w_arm      = inew_sample_trigger &&
                      ($signed(isample_filtered) > $signed(ithreshold));
  assign w_win_eff  = (iwindow_len == '0) ? WIN_W'(1) : iwindow_len;
  assign w_cnt_inc  = {1'b0, r_cnt} + (WIN_W+1)'(1);
  assign w_scan_val = r_max[r_idx];

  // Unpack the flat correlation bus into per-channel signed values
  always_comb begin
    for (int unsigned k = 0; k < N_SEQ; k++) begin
      w_corr[k] = icorrelation[k*CORR_W +: CORR_W];
    end
  end

  // State register
  always_ff @(posedge crx_clk) begin
    if (w_clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_arm) begin
          w_state_next = (w_win_eff == WIN_W'(1)) ? ST_SCAN : ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (inew_sample_trigger && (w_cnt_inc >= {1'b0, w_win_eff})) begin
          w_state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_idx == SEQ_W'(N_SEQ-1)) begin
          w_state_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (r_valid && iresult_acquired) begin
          w_state_next = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (ihold_off == '0) begin
          w_state_next = ST_IDLE;
        end else if (inew_sample_trigger && (w_cnt_inc >= {1'b0, ihold_off})) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Window/hold-off counter, per-channel maxima, scan and result registers
  always_ff @(posedge crx_clk) begin
    if (w_clear) begin
      r_cnt        <= '0;
      for (int unsigned k = 0; k < N_SEQ; k++) begin
        r_max[k]  <= MOST_NEG;
        r_time[k] <= '0;
      end
      r_idx        <= '0;
      r_best       <= MOST_NEG;
      r_second     <= MOST_NEG;
      r_best_seq   <= '0;
      r_best_time  <= '0;
      r_out_value  <= '0;
      r_out_second <= '0;
      r_out_seq    <= '0;
      r_out_time   <= '0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_SEARCH: begin
          // Scan registers are kept primed so SCAN starts cleanly at index 0
          r_idx       <= '0;
          r_best      <= MOST_NEG;
          r_second    <= MOST_NEG;
          r_best_seq  <= '0;
          r_best_time <= '0;
          if (r_state == ST_IDLE) begin
            if (w_arm) begin
              for (int unsigned k = 0; k < N_SEQ; k++) begin
                r_max[k]  <= w_corr[k];
                r_time[k] <= icurrent_time;
              end
              r_cnt <= WIN_W'(1);
            end
          end else if (inew_sample_trigger) begin
            for (int unsigned k = 0; k < N_SEQ; k++) begin
              if (w_corr[k] > r_max[k]) begin
                r_max[k]  <= w_corr[k];
                r_time[k] <= icurrent_time;
              end
            end
            if (w_cnt_inc <= {1'b0, w_win_eff}) begin
              r_cnt <= w_cnt_inc[WIN_W-1:0];
            end
          end
        end
        ST_SCAN: begin
          // Strict compares keep the lower index on equal peaks
          if (w_scan_val > r_best) begin
            r_second    <= r_best;
            r_best      <= w_scan_val;
            r_best_seq  <= r_idx;
            r_best_time <= r_time[r_idx];
          end else if (w_scan_val > r_second) begin
            r_second <= w_scan_val;
          end
          r_idx <= r_idx + SEQ_W'(1);
        end
        ST_REPORT: begin
          if (!r_valid) begin
            r_out_value  <= r_best;
            r_out_second <= r_second;
            r_out_seq    <= r_best_seq;
            r_out_time   <= r_best_time;
            r_valid      <= 1'b1;
          end else if (iresult_acquired) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_HOLDOFF: begin
          if (inew_sample_trigger && (ihold_off != '0)) begin
            r_cnt <= w_cnt_inc[WIN_W-1:0];
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign o_peak_value   = r_out_value;
  assign o_second_value = r_out_second;
  assign o_peak_seq     = r_out_seq;
  assign o_peak_time    = r_out_time;
  assign o_valid        = r_valid;
  assign o_busy         = (r_state != ST_IDLE);

endmodule
